chain_tap_sum: RTL

- Parametrised sliding-window tap-sum engine; generalises the fixed 3-register chain-and-add datapath to configurable width, depth and tap selection.
- Adds valid/ready flow control, warm-up tracking, flush, and wrap/saturate output modes.
- Sits between a streaming sample source and consumer in the graph-test datapath. Instances chain output-to-input.

---
 rtl/chain_tap_sum_pkg.sv | 22 ++
 rtl/chain_tap_sum_if.sv | 11 +
 rtl/chain_tap_stage.sv | 18 +
 rtl/chain_tap_sum.sv | 94 +++++++++
 4 files changed

// File: rtl/chain_tap_sum_pkg.sv
// Shared types and width helpers for the sliding-window tap-sum engine.
package chain_tap_sum_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_t;

    // Widest sample width the saturation constant can describe.
    localparam int SAT_MAX_W = 64;

    // Adder width that can hold DEPTH full-scale samples without overflow.
    function automatic int sum_width(input int width, input int depth);
        return width + $clog2(depth);
    endfunction

    // Largest unsigned value representable in 'width' bits.
    function automatic logic [SAT_MAX_W-1:0] sat_max(input int width);
        return (SAT_MAX_W'(1) << width) - SAT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/chain_tap_sum_if.sv
// One valid/ready sample stream; the producer side is master, the consumer side is slave.
interface chain_tap_sum_if #(
    parameter int WIDTH = 4
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/chain_tap_stage.sv
// One window tap: WIDTH-bit register that loads on enable and clears synchronously.
module chain_tap_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear wins over load so reset/flush always leave an empty window.
    always_ff @(posedge clk) begin
        if (clr)     q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/chain_tap_sum.sv
// Sliding-window tap-sum engine: a DEPTH-stage sample chain, a selectable
// tap adder, warm-up tracking and a single output register with valid/ready.
module chain_tap_sum
    import chain_tap_sum_pkg::*;
#(
    parameter int    WIDTH = 4,
    parameter int    DEPTH = 3,
    parameter mode_t MODE  = MODE_WRAP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [DEPTH-1:0]   tap_en,
    chain_tap_sum_if.slave     in_s,
    chain_tap_sum_if.master    out_m
);

    localparam int                SUM_W   = sum_width(WIDTH, DEPTH);
    localparam int                CNT_W   = $clog2(DEPTH);
    localparam logic [SUM_W-1:0]  SAT_MAX = SUM_W'(sat_max(WIDTH));
    localparam logic [CNT_W-1:0]  FULL_AT = CNT_W'(DEPTH - 1);

    logic [DEPTH-1:0][WIDTH-1:0] tap_q;
    logic [DEPTH-1:0][WIDTH-1:0] chain_d;
    logic [SUM_W-1:0]            sum;
    logic [WIDTH-1:0]            result;
    logic [CNT_W-1:0]            fill_cnt;
    logic                        full;
    logic                        accept;
    logic                        clr;
    logic                        out_valid;
    logic [WIDTH-1:0]            out_data;
    logic                        unused_tail;

    assign clr    = rst | flush;
    assign full   = (fill_cnt == FULL_AT);

    // Ready never looks at in_valid; a flush cycle refuses input outright.
    assign in_s.ready = !flush && (!out_valid || out_m.ready);
    assign accept     = in_s.valid && in_s.ready;

    assign out_m.valid = out_valid;
    assign out_m.data  = out_data;

    // Each stage takes its upstream neighbour; stage 0 takes the new sample.
    assign chain_d = {tap_q[DEPTH-2:0], in_s.data};

    // The oldest tap only ages out of the window, so it never feeds the adder.
    assign unused_tail = ^tap_q[DEPTH-1];

    for (genvar k = 0; k < DEPTH; k++) begin : g_tap
        chain_tap_stage #(.WIDTH(WIDTH)) u_stage (
            .clk (clk),
            .clr (clr),
            .en  (accept),
            .d   (chain_d[k]),
            .q   (tap_q[k])
        );
    end

    // Sum the post-shift window: incoming sample as tap 0, t[k-1] as tap k.
    always_comb begin
        sum = tap_en[0] ? SUM_W'(in_s.data) : '0;
        for (int k = 1; k < DEPTH; k++) begin
            if (tap_en[k]) sum = sum + SUM_W'(tap_q[k-1]);
        end
    end

    // Narrow the full-precision sum to WIDTH bits by wrapping or clamping.
    always_comb begin
        result = sum[WIDTH-1:0];
        if (MODE == MODE_SAT && sum > SAT_MAX) result = SAT_MAX[WIDTH-1:0];
    end

    // Count warm-up accepts; stops once the window holds DEPTH-1 samples.
    always_ff @(posedge clk) begin
        if (clr)                 fill_cnt <= '0;
        else if (accept && !full) fill_cnt <= fill_cnt + 1'b1;
    end

    // Output register: load on a full-window accept, else retire when taken.
    always_ff @(posedge clk) begin
        if (clr) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept && full) begin
            out_valid <= 1'b1;
            out_data  <= result;
        end else if (out_m.ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
